// File: rtl/mem_slot_ctrl_pkg.sv
// rtl/mem_slot_ctrl_pkg.sv - shared types and slot constants for the slot write controller
package mem_slot_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_REQ0 = 2'd0,
    SRC_REQ1 = 2'd1,
    SRC_STAT = 2'd2
  } src_t;

  localparam logic [1:0] SLOT_STATUS = 2'd3;
  localparam logic [1:0] SLOT_LAST   = 2'd2;
  localparam logic [1:0] SLOT_FIRST  = 2'd0;

endpackage

// File: rtl/mem_slot_ctrl_if.sv
// rtl/mem_slot_ctrl_if.sv - requester, status and store-side signal bundle
interface mem_slot_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              req0;
  logic [DATA_W-1:0] wdata0;
  logic              req1;
  logic [DATA_W-1:0] wdata1;
  logic              stat_evt;
  logic [DATA_W-1:0] stat_data;
  logic              gnt0;
  logic              gnt1;
  logic              stat_ack;
  logic [1:0]        mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;

  modport slave (
    input  req0, wdata0, req1, wdata1, stat_evt, stat_data,
    output gnt0, gnt1, stat_ack, mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output req0, wdata0, req1, wdata1, stat_evt, stat_data,
    input  gnt0, gnt1, stat_ack, mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/mem_slot_ctrl_slot_counter.sv
// rtl/mem_slot_ctrl_slot_counter.sv - requester slot counter cycling SLOT_FIRST..SLOT_LAST
module slot_counter
  import mem_slot_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= SLOT_FIRST;
    end else if (inc) begin
      cnt <= (cnt >= SLOT_LAST) ? SLOT_FIRST : cnt + 2'd1;
    end
  end

endmodule

// File: rtl/mem_slot_ctrl.sv
// rtl/mem_slot_ctrl.sv - arbitrates two requesters and a sticky status event onto a 4-slot store
module mem_slot_ctrl
  import mem_slot_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_slot_ctrl_if.slave  bus
);

  state_t            state, state_nxt;
  src_t              src, src_nxt;
  logic              rr;
  logic              stat_pend;
  logic [1:0]        cnt;
  logic              leave_idle;
  logic [1:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              cnt_inc;
  logic              stat_clr;

  assign cnt_inc  = (state == WRITE) && (src != SRC_STAT);
  assign stat_clr = (state == WRITE) && (src == SRC_STAT);

  slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    src_nxt       = src;
    leave_idle    = 1'b0;
    sel_addr      = SLOT_STATUS;
    sel_data      = bus.stat_data;
    bus.mem_we    = 1'b0;
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.stat_ack  = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        leave_idle = stat_pend | bus.req0 | bus.req1;
        // rr=0 favours req0 only when both are asking; a lone request always wins
        if (stat_pend) begin
          src_nxt = SRC_STAT;
        end else if (bus.req0 && (!bus.req1 || !rr)) begin
          src_nxt = SRC_REQ0;
        end else if (bus.req1) begin
          src_nxt = SRC_REQ1;
        end
        if (leave_idle) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        bus.mem_we = 1'b1;
        state_nxt  = ACK;
      end
      ACK: begin
        bus.gnt0     = (src == SRC_REQ0);
        bus.gnt1     = (src == SRC_REQ1);
        bus.stat_ack = (src == SRC_STAT);
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    case (src_nxt)
      SRC_REQ0: begin
        sel_addr = cnt;
        sel_data = bus.wdata0;
      end
      SRC_REQ1: begin
        sel_addr = cnt;
        sel_data = bus.wdata1;
      end
      default: begin
        sel_addr = SLOT_STATUS;
        sel_data = bus.stat_data;
      end
    endcase
  end

  // Transaction context is captured once on leaving IDLE so later input changes cannot leak in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src           <= SRC_REQ0;
      rr            <= 1'b0;
      stat_pend     <= 1'b0;
      bus.mem_addr  <= 2'd0;
      bus.mem_wdata <= '0;
    end else begin
      stat_pend <= bus.stat_evt | (stat_pend & ~stat_clr);
      if (leave_idle) begin
        src           <= src_nxt;
        bus.mem_addr  <= sel_addr;
        bus.mem_wdata <= sel_data;
        if (src_nxt != SRC_STAT) begin
          rr <= (src_nxt == SRC_REQ0);
        end
      end
    end
  end

endmodule
